// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch front end.
//
// Drives the instruction ROM (chip enable plus word address taken from the
// program counter) and captures the word the ROM returns combinationally in
// the same cycle. Each fetched {pc, inst} pair is written into a small FIFO,
// and decode drains the FIFO over a valid/ready handshake. A redirect loads a
// new PC and flushes everything in flight.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   rom_ce_o       ROM chip enable (a fetch happens in every cycle it is high)
//   rom_addr_o     ROM word address, pc[ADDR_W+1:2]
//   rom_inst_i     ROM instruction word, valid while rom_ce_o=1
//   redirect_i     load redirect_pc_i into the PC and flush the buffer
//   redirect_pc_i  redirect target (low two bits ignored)
//   id_valid_o     head buffer entry is valid
//   id_inst_o      head entry instruction
//   id_pc_o        head entry PC
//   id_ready_i     decode accepts the head entry this cycle
//   dbg_fetch_o    FSM state: 0 = IDLE, 1 = FETCH
//
// Handshake: an entry moves to decode on every rising edge where id_valid_o
// and id_ready_i are both high; id_valid_o never depends on id_ready_i, and
// id_pc_o/id_inst_o stay stable while id_valid_o is high and not accepted.
// A redirect in the same cycle overrides the transfer (nothing is consumed).
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 6,
  parameter int          DEPTH    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [31:0]       rom_inst_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic              id_valid_o,
  output logic [31:0]       id_inst_o,
  output logic [31:0]       id_pc_o,
  input  logic              id_ready_i,
  output logic              dbg_fetch_o
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t           state;
  logic [31:0]      pc;
  logic [63:0]      buf_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  // Fetch enable looks only at registered state and redirect_i, so decode
  // backpressure never reaches the ROM combinationally; a slot freed by a pop
  // is refilled one cycle later.
  assign rom_ce_o    = (state == FETCH) && (count < FULL_CNT) && !redirect_i;
  assign rom_addr_o  = pc[ADDR_W+1:2];
  assign id_valid_o  = (count != '0);
  assign {id_pc_o, id_inst_o} = buf_mem[rd_ptr];
  assign dbg_fetch_o = (state == FETCH);

  assign push = rom_ce_o;
  assign pop  = id_valid_o && id_ready_i && !redirect_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else begin
      // IDLE lasts exactly one cycle after reset, redirect or not.
      if (state == IDLE) begin
        state <= FETCH;
      end

      if (redirect_i) begin
        // Flush: buffered entries are dropped, a same-cycle pop is ignored.
        pc     <= {redirect_pc_i[31:2], 2'b00};
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          buf_mem[wr_ptr] <= {pc, rom_inst_i};
          wr_ptr          <= wr_ptr + PTR_W'(1);
          pc              <= pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + (PTR_W + 1)'(1);
          2'b01:   count <= count - (PTR_W + 1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch with a behavioural ROM
// (word n holds 0x1000_0000 + n) and a queue of expected {pc, inst} pairs
// that decode should accept, in order.
module tb_inst_fetch;

  localparam int ADDR_W = 6;

  logic              clk;
  logic              rst_i;
  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [31:0]       rom_inst_i;
  logic              redirect_i;
  logic [31:0]       redirect_pc_i;
  logic              id_valid_o;
  logic [31:0]       id_inst_o;
  logic [31:0]       id_pc_o;
  logic              id_ready_i;
  logic              dbg_fetch_o;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  inst_fetch #(
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (ADDR_W),
    .DEPTH    (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .rom_ce_o      (rom_ce_o),
    .rom_addr_o    (rom_addr_o),
    .rom_inst_i    (rom_inst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_valid_o    (id_valid_o),
    .id_inst_o     (id_inst_o),
    .id_pc_o       (id_pc_o),
    .id_ready_i    (id_ready_i),
    .dbg_fetch_o   (dbg_fetch_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM.
  assign rom_inst_i = 32'h1000_0000 + 32'(rom_addr_o);

  // ---------------- helpers ----------------
  function automatic logic [63:0] exp_word(input logic [31:0] pc);
    return {pc, 32'h1000_0000 + 32'(pc[ADDR_W+1:2])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk_fetch(input string tag, input logic ce, input logic [31:0] addr);
    chk({tag, "_ce"}, 32'(rom_ce_o), 32'(ce));
    if (ce) chk({tag, "_addr"}, 32'(rom_addr_o), addr);
  endtask

  task automatic chk_head(input string tag, input logic valid, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(id_valid_o), 32'(valid));
    if (valid) chk({tag, "_pc"}, id_pc_o, pc);
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back(exp_word(pc));
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_i && !redirect_i && id_valid_o && id_ready_i) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_pop: observed pc %h inst %h, expected none", id_pc_o, id_inst_o);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        tests++;
        assert ({id_pc_o, id_inst_o} === mon_exp) else begin
          fails++;
          $error("FAIL pop_pair: observed %h expected %h", {id_pc_o, id_inst_o}, mon_exp);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = $urandom;
    id_ready_i    = 1'b0;
    repeat (2) @(posedge clk);
    settle();
    chk("rst_ce", 32'(rom_ce_o), 32'd0);
    chk("rst_addr", 32'(rom_addr_o), 32'd0);
    chk("rst_valid", 32'(id_valid_o), 32'd0);
    chk("rst_inst", id_inst_o, 32'd0);
    chk("rst_pc", id_pc_o, 32'd0);
    chk("rst_state", 32'(dbg_fetch_o), 32'd0);

    // Release reset with decode always ready: one pair per cycle.
    step();
    rst_i      = 1'b0;
    id_ready_i = 1'b1;
    for (int n = 0; n < 7; n++) push_exp(32'(n * 4));
    settle();
    chk("idle_ce", 32'(rom_ce_o), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      redirect_pc_i = $urandom;
      settle();
      chk_fetch("stream", 1'b1, 32'(i));
      chk("stream_valid", 32'(id_valid_o), (i > 0) ? 32'd1 : 32'd0);
    end

    // Redirect together with a pop: flush wins, pc 28 is never accepted.
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0000;
    settle();
    chk_fetch("rdpop", 1'b0, 32'd0);
    chk_head("rdpop", 1'b1, 32'd28);

    // Backpressure: ready low for five cycles after the first fetch.
    step();
    redirect_i    = 1'b0;
    redirect_pc_i = $urandom;
    id_ready_i    = 1'b0;
    settle();
    chk_fetch("bp0", 1'b1, 32'd0);
    chk_head("bp0", 1'b0, 32'd0);
    step();
    settle();
    chk_fetch("bp1", 1'b1, 32'd1);
    chk_head("bp1", 1'b1, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      settle();
      chk("bp_full_ce", 32'(rom_ce_o), 32'd0);
      chk("bp_full_addr", 32'(rom_addr_o), 32'd2);
      chk_head("bp_full", 1'b1, 32'd0);
    end
    push_exp(32'd0);
    push_exp(32'd4);
    push_exp(32'd8);
    push_exp(32'd12);
    step();
    id_ready_i = 1'b1;
    settle();
    chk_fetch("drain0", 1'b0, 32'd0);
    chk_head("drain0", 1'b1, 32'd0);
    step();
    settle();
    chk_fetch("drain1", 1'b1, 32'd2);
    chk_head("drain1", 1'b1, 32'd4);
    step();
    settle();
    chk_fetch("drain2", 1'b1, 32'd3);
    chk_head("drain2", 1'b1, 32'd8);
    step();
    settle();
    chk_fetch("drain3", 1'b1, 32'd4);
    chk_head("drain3", 1'b1, 32'd12);

    // Fill the buffer, then redirect to a misaligned target.
    step();
    id_ready_i = 1'b0;
    settle();
    chk_fetch("fill", 1'b1, 32'd5);
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0043;
    settle();
    chk_fetch("redir", 1'b0, 32'd0);
    chk_head("redir", 1'b1, 32'd16);
    step();
    redirect_i    = 1'b0;
    redirect_pc_i = $urandom;
    id_ready_i    = 1'b1;
    push_exp(32'h40);
    settle();
    chk_fetch("redir_t1", 1'b1, 32'h10);
    chk_head("redir_t1", 1'b0, 32'd0);
    step();
    settle();
    chk_fetch("redir_t2", 1'b1, 32'h11);
    chk_head("redir_t2", 1'b1, 32'h40);
    chk("redir_t2_inst", id_inst_o, 32'h1000_0010);

    // Address aliasing at the top of the ROM.
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_00FC;
    settle();
    chk_fetch("wrap_rd", 1'b0, 32'd0);
    step();
    redirect_i    = 1'b0;
    redirect_pc_i = $urandom;
    push_exp(32'hFC);
    push_exp(32'h100);
    settle();
    chk_fetch("wrap0", 1'b1, 32'd63);
    chk_head("wrap0", 1'b0, 32'd0);
    step();
    settle();
    chk_fetch("wrap1", 1'b1, 32'd0);
    chk_head("wrap1", 1'b1, 32'hFC);
    step();
    settle();
    chk_fetch("wrap2", 1'b1, 32'd1);
    chk_head("wrap2", 1'b1, 32'h100);

    // 32-bit PC wrap.
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    settle();
    chk_fetch("pcwrap_rd", 1'b0, 32'd0);
    step();
    redirect_i    = 1'b0;
    redirect_pc_i = $urandom;
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0);
    settle();
    chk_fetch("pcwrap0", 1'b1, 32'd63);
    step();
    settle();
    chk_fetch("pcwrap1", 1'b1, 32'd0);
    chk_head("pcwrap1", 1'b1, 32'hFFFF_FFFC);
    step();
    settle();
    chk_head("pcwrap2", 1'b1, 32'h0);

    // Fill, then reset mid-stream with a redirect asserted (reset wins).
    step();
    id_ready_i = 1'b0;
    settle();
    step();
    settle();
    chk_fetch("full_pre_rst", 1'b0, 32'd0);
    chk_head("full_pre_rst", 1'b1, 32'd4);
    step();
    rst_i         = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0080;
    settle();
    step();
    rst_i         = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = $urandom;
    id_ready_i    = 1'b1;
    push_exp(32'h0);
    settle();
    chk_fetch("post_rst", 1'b0, 32'd0);
    chk("post_rst_addr", 32'(rom_addr_o), 32'd0);
    chk_head("post_rst", 1'b0, 32'd0);
    step();
    settle();
    chk_fetch("restart0", 1'b1, 32'd0);
    chk_head("restart0", 1'b0, 32'd0);
    step();
    settle();
    chk_fetch("restart1", 1'b1, 32'd1);
    chk_head("restart1", 1'b1, 32'd0);
    step();
    id_ready_i = 1'b0;
    settle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
